// File: rtl/mpsoc_axi4_mem2axi_master_if.sv
// AXI4 channel bundle between the mem2axi initiator and its slave.
// The master modport drives AW/W/AR payloads and the B/R ready signals.
interface mpsoc_axi4_mem2axi_master_if #(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = 4,
  parameter int AXI_USER_WIDTH = 10
) ();
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/mpsoc_axi4_mem2axi_master.sv
// Single-outstanding bridge from a req/gnt memory port to single-beat AXI4
// reads and writes; completion is signalled by a one-cycle ack_o pulse.
module mpsoc_axi4_mem2axi_master #(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = 4,
  parameter int AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [AXI_STRB_WIDTH-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0] data_i,
  output logic                      gnt_o,
  output logic                      ack_o,
  output logic [AXI_DATA_WIDTH-1:0] data_o,
  output logic                      err_o,
  mpsoc_axi4_mem2axi_master_if.master axi
);
  localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_STRB_WIDTH));

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

  state_t                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_STRB_WIDTH-1:0] be_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
  logic aw_done_q, w_done_q, ack_q, err_q;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done_d, w_done_d;

  assign aw_hs     = aw_valid_q & axi.aw_ready;
  assign w_hs      = w_valid_q & axi.w_ready;
  assign ar_hs     = ar_valid_q & axi.ar_ready;
  assign b_hs      = b_ready_q & axi.b_valid;
  assign r_hs      = r_ready_q & axi.r_valid;
  // Done flags include the current handshake so WRITE exits the same cycle the later one lands.
  assign aw_done_d = aw_done_q | aw_hs;
  assign w_done_d  = w_done_q | w_hs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q    <= addr_i;
            be_q      <= be_i;
            wdata_q   <= data_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (we_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= WRITE;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= RADDR;
            end
          end
        end
        WRITE: begin
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs) w_valid_q <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            b_ready_q <= 1'b1;
            state_q   <= WRESP;
          end
        end
        WRESP: begin
          if (b_hs) begin
            b_ready_q <= 1'b0;
            ack_q     <= 1'b1;
            err_q     <= axi.b_resp[1];
            state_q   <= IDLE;
          end
        end
        RADDR: begin
          if (ar_hs) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= RDATA;
          end
        end
        RDATA: begin
          if (r_hs) begin
            r_ready_q <= 1'b0;
            rdata_q   <= axi.r_data;
            ack_q     <= 1'b1;
            err_q     <= axi.r_resp[1] | ~axi.r_last;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o  = (state_q == IDLE);
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign data_o = rdata_q;

  assign axi.aw_id     = TXN_ID;
  assign axi.aw_addr   = addr_q;
  assign axi.aw_len    = 8'd0;
  assign axi.aw_size   = AXI_SIZE;
  assign axi.aw_burst  = 2'b01;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = 4'b0011;
  assign axi.aw_prot   = 3'b000;
  assign axi.aw_qos    = 4'd0;
  assign axi.aw_region = 4'd0;
  assign axi.aw_user   = '0;
  assign axi.aw_valid  = aw_valid_q;

  assign axi.w_data  = wdata_q;
  assign axi.w_strb  = be_q;
  assign axi.w_last  = 1'b1;
  assign axi.w_user  = '0;
  assign axi.w_valid = w_valid_q;

  assign axi.b_ready = b_ready_q;

  assign axi.ar_id     = TXN_ID;
  assign axi.ar_addr   = addr_q;
  assign axi.ar_len    = 8'd0;
  assign axi.ar_size   = AXI_SIZE;
  assign axi.ar_burst  = 2'b01;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = 4'b0011;
  assign axi.ar_prot   = 3'b000;
  assign axi.ar_qos    = 4'd0;
  assign axi.ar_region = 4'd0;
  assign axi.ar_user   = '0;
  assign axi.ar_valid  = ar_valid_q;

  assign axi.r_ready = r_ready_q;

  // Returned IDs/users are irrelevant with a single transaction in flight.
  logic unused_rsp;
  assign unused_rsp = ^{axi.b_id, axi.b_user, axi.b_resp[0], axi.r_id, axi.r_user,
                        axi.r_resp[0]};
endmodule

// File: tb/tb_mpsoc_axi4_mem2axi_master.sv
// Scoreboard bench: a memory-like AXI slave with programmable stalls, a word-array
// reference model for expected responses, and a monitor that checks every handshake/ack.
module tb_mpsoc_axi4_mem2axi_master;
  localparam int P = 10;

  typedef struct {
    bit          we;
    bit          err;
    logic [31:0] data;
    longint      t_ack;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, ack, err;
  logic [31:0] rdata;

  int n_chk = 0, n_fail = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  int n_aw_hs = 0, n_w_hs = 0, last_ar_hold = 0;
  bit chk_lat = 0;
  logic [31:0] smem [256];
  logic [31:0] rmem [256];
  exp_t        exp_q[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] ar_q[$];

  mpsoc_axi4_mem2axi_master_if #(.AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .AXI_STRB_WIDTH(4), .AXI_USER_WIDTH(10)) axi ();

  mpsoc_axi4_mem2axi_master #(.AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .AXI_STRB_WIDTH(4), .AXI_USER_WIDTH(10), .TXN_ID(10'h2A)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .data_i(wdata), .gnt_o(gnt), .ack_o(ack), .data_o(rdata), .err_o(err), .axi(axi));

  always #(P/2) clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Slave: region addr[9:8]==3 answers SLVERR, region 2 returns reads with r_last=0.
  initial begin : slave
    int aw_c = 0, w_c = 0, ar_c = 0, r_c = 0, b_c = 0;
    bit have_aw = 0, have_w = 0, have_ar = 0, b_fire = 0, r_fire = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_strb = '0;
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0; axi.b_valid = 0; axi.r_valid = 0;
    axi.b_id = '0; axi.b_resp = '0; axi.b_user = '0;
    axi.r_id = '0; axi.r_data = '0; axi.r_resp = '0; axi.r_last = 0; axi.r_user = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0; axi.b_valid = 0; axi.r_valid = 0;
        aw_c = 0; w_c = 0; ar_c = 0; r_c = 0; b_c = 0;
        have_aw = 0; have_w = 0; have_ar = 0; b_fire = 0; r_fire = 0;
        continue;
      end
      if (axi.aw_ready) begin axi.aw_ready = 0; have_aw = 1; end
      else if (axi.aw_valid && !have_aw) begin
        if (aw_c >= aw_dly) begin axi.aw_ready = 1; s_awaddr = axi.aw_addr; aw_c = 0; end
        else aw_c++;
      end
      if (axi.w_ready) begin axi.w_ready = 0; have_w = 1; end
      else if (axi.w_valid && !have_w) begin
        if (w_c >= w_dly) begin
          axi.w_ready = 1; s_wdata = axi.w_data; s_strb = axi.w_strb; w_c = 0;
        end else w_c++;
      end
      if (axi.ar_ready) begin axi.ar_ready = 0; have_ar = 1; end
      else if (axi.ar_valid && !have_ar) begin
        if (ar_c >= ar_dly) begin axi.ar_ready = 1; s_araddr = axi.ar_addr; ar_c = 0; end
        else ar_c++;
      end
      if (b_fire) begin axi.b_valid = 0; b_fire = 0; have_aw = 0; have_w = 0; end
      else if (!axi.b_valid && have_aw && have_w) begin
        if (b_c >= b_dly) begin
          b_c = 0; axi.b_valid = 1; axi.b_id = 10'($urandom);
          if (s_awaddr[9:8] == 2'b11) axi.b_resp = 2'b10;
          else begin
            axi.b_resp = 2'b00;
            for (int i = 0; i < 4; i++)
              if (s_strb[i]) smem[s_awaddr[9:2]][8*i +: 8] = s_wdata[8*i +: 8];
          end
        end else b_c++;
      end
      if (axi.b_valid && !b_fire && axi.b_ready) b_fire = 1;
      if (r_fire) begin axi.r_valid = 0; r_fire = 0; have_ar = 0; end
      else if (!axi.r_valid && have_ar) begin
        if (r_c >= r_dly) begin
          r_c = 0; axi.r_valid = 1; axi.r_id = 10'($urandom);
          axi.r_data = smem[s_araddr[9:2]];
          axi.r_resp = (s_araddr[9:8] == 2'b11) ? 2'b10 : 2'b00;
          axi.r_last = (s_araddr[9:8] != 2'b10);
        end else r_c++;
      end
      if (axi.r_valid && !r_fire && axi.r_ready) r_fire = 1;
    end
  end

  initial begin : monitor
    exp_t e;
    bit p_rst = 1, p_aw_hs = 0, p_w_hs = 0, p_ar_hs = 0, aw_hs, w_hs, ar_hs;
    logic p_awv = 0, p_wv = 0, p_arv = 0;
    logic [31:0] p_awaddr = '0, p_araddr = '0;
    logic [35:0] p_w = '0;
    int outst = 0, ar_hold = 0;
    forever begin
      @(negedge clk); #2;
      if (!p_rst) begin
        if (p_awv && !p_aw_hs) begin
          chk("aw_valid_hold", axi.aw_valid, 1); chk("aw_addr_stable", axi.aw_addr, p_awaddr);
        end
        if (p_wv && !p_w_hs) begin
          chk("w_valid_hold", axi.w_valid, 1); chk("w_payload_stable", {axi.w_strb, axi.w_data}, p_w);
        end
        if (p_arv && !p_ar_hs) begin
          chk("ar_valid_hold", axi.ar_valid, 1); chk("ar_addr_stable", axi.ar_addr, p_araddr);
        end
        if (p_aw_hs) chk("aw_valid_drop", axi.aw_valid, 0);
        if (p_w_hs) chk("w_valid_drop", axi.w_valid, 0);
        if (p_ar_hs) chk("ar_valid_drop", axi.ar_valid, 0);
      end
      if (ack) begin
        chk("ack_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ack_err", err, e.err);
          if (!e.we) chk("ack_rdata", rdata, e.data);
          if (e.t_ack != 0) chk("ack_latency", $time, e.t_ack);
        end
      end
      aw_hs = axi.aw_valid && axi.aw_ready;
      w_hs  = axi.w_valid && axi.w_ready;
      ar_hs = axi.ar_valid && axi.ar_ready;
      if (rst) begin outst = 0; ar_hold = 0; end
      else begin
        if (axi.ar_valid) ar_hold++;
        if (aw_hs) begin
          chk("aw_one_outstanding", outst, 0); outst++; n_aw_hs++;
          chk("aw_queue_nonempty", aw_q.size(), 1);
          if (aw_q.size() != 0) chk("aw_addr", axi.aw_addr, aw_q.pop_front());
          chk("aw_fields", {axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock, axi.aw_cache,
              axi.aw_prot, axi.aw_qos, axi.aw_region}, {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011,
              3'b000, 4'd0, 4'd0});
          chk("aw_id_user", {axi.aw_id, axi.aw_user}, {10'h2A, 10'h0});
        end
        if (w_hs) begin
          n_w_hs++;
          chk("w_queue_nonempty", w_q.size(), 1);
          if (w_q.size() != 0) chk("w_strb_data", {axi.w_strb, axi.w_data}, w_q.pop_front());
          chk("w_last_user", {axi.w_last, axi.w_user}, {1'b1, 10'h0});
        end
        if (ar_hs) begin
          chk("ar_one_outstanding", outst, 0); outst++;
          last_ar_hold = ar_hold; ar_hold = 0;
          chk("ar_queue_nonempty", ar_q.size(), 1);
          if (ar_q.size() != 0) chk("ar_addr", axi.ar_addr, ar_q.pop_front());
          chk("ar_fields", {axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock, axi.ar_cache,
              axi.ar_prot, axi.ar_qos, axi.ar_region, axi.ar_id, axi.ar_user},
              {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0, 4'd0, 10'h2A, 10'h0});
        end
        if (axi.b_valid && axi.b_ready) outst--;
        if (axi.r_valid && axi.r_ready) outst--;
      end
      p_rst = rst; p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs;
      p_awv = axi.aw_valid; p_wv = axi.w_valid; p_arv = axi.ar_valid;
      p_awaddr = axi.aw_addr; p_araddr = axi.ar_addr; p_w = {axi.w_strb, axi.w_data};
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
    exp_t e;
    int cnt = 0;
    req = 1; we = w; addr = a; be = b; wdata = d;
    while (!gnt && cnt < 500) begin @(negedge clk); cnt++; end
    chk("grant_seen", gnt, 1);
    if (!gnt) begin req = 0; return; end
    @(posedge clk);
    e.we = w;
    if (w) begin
      e.err  = (a[9:8] == 2'b11);
      e.data = '0;
      if (!e.err)
        for (int i = 0; i < 4; i++) if (b[i]) rmem[a[9:2]][8*i +: 8] = d[8*i +: 8];
      aw_q.push_back(a);
      w_q.push_back({b, d});
    end else begin
      e.err  = a[9];
      e.data = rmem[a[9:2]];
      ar_q.push_back(a);
    end
    e.t_ack = chk_lat ? longint'($time) + 27 : 0;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin @(negedge clk); #3; cnt++; end
    chk("completion_in_time", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #(P * 40000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] saved;
    for (int i = 0; i < 256; i++) begin smem[i] = $urandom; rmem[i] = smem[i]; end
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 1);
    chk("rst_valid_ready", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
    chk("rst_ack_err", {ack, err}, 0);
    chk("rst_data", rdata, 0);
    rst = 0;
    @(negedge clk);

    chk_lat = 1;
    issue(1, 32'h100, 4'hF, 32'hDEADBEEF); req = 0; wait_done();
    issue(0, 32'h100, 4'hF, 32'h0); req = 0; wait_done();
    chk_lat = 0;

    smem[16] = 32'h12345678; rmem[16] = 32'h12345678;
    ar_dly = 3; r_dly = 2;
    issue(0, 32'h40, 4'hF, 32'h0); req = 0; wait_done();
    chk("ar_hold_cycles", last_ar_hold, 4);
    ar_dly = 0; r_dly = 0;

    begin
      int aw0, w0;
      aw0 = n_aw_hs; w0 = n_w_hs; w_dly = 2;
      issue(1, 32'h84, 4'h3, 32'hCAFEF00D); req = 0; wait_done();
      chk("aw_count", n_aw_hs - aw0, 1);
      chk("w_count", n_w_hs - w0, 1);
      w_dly = 0;
    end

    issue(1, 32'h300, 4'hF, 32'h11111111); req = 0; wait_done();
    issue(0, 32'h204, 4'hF, 32'h0);
    issue(0, 32'h304, 4'hF, 32'h0); req = 0; wait_done();

    chk_lat = 1;
    issue(0, 32'h0, 4'hF, 32'h0);
    issue(0, 32'h4, 4'hF, 32'h0);
    issue(0, 32'h8, 4'hF, 32'h0); req = 0; wait_done();
    chk_lat = 0;

    aw_dly = 50; w_dly = 50;
    saved = rmem[72];
    issue(1, 32'h120, 4'hF, 32'h55AA55AA); req = 0;
    @(negedge clk);
    rst = 1; rmem[72] = saved;
    exp_q.delete(); aw_q.delete(); w_q.delete(); ar_q.delete();
    @(negedge clk); #3;
    chk("midrst_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid}, 0);
    chk("midrst_gnt", gnt, 1);
    chk("midrst_ack", ack, 0);
    rst = 0; aw_dly = 0; w_dly = 0;
    repeat (3) begin @(negedge clk); #3; chk("midrst_no_ack", ack, 0); end

    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      a = $urandom & 32'hFFFF_FFFC;
      issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        req = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req = 0; wait_done();
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size() + aw_q.size() + w_q.size() + ar_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
